// File: rtl/k11.sv
`default_nettype none
// ============================================================================
// Module  : k11
// Brief   : Pipelined IEEE-754 single complex multiply by W5^1 = cos72 - j*sin72.
//           Define K11_ROUND_EN for round-to-nearest-even; truncation otherwise.
// Revision: 1.0
// ============================================================================
module k11 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_re,
    input  logic [31:0] a_img,
    output logic [31:0] a1_re,
    output logic [31:0] a1_img
);
    localparam logic [31:0] c_cos = 32'h3E9E377A;
    localparam logic [31:0] c_sin = 32'h3F737871;

    // Applies the rounding increment and clamps the exponent to zero/Inf.
    function automatic logic [31:0] f_pack(
        input logic              sign,
        input logic signed [9:0] e_in,
        input logic [22:0]       frac,
        input logic              inc
    );
        logic [23:0]       v_man;
        logic signed [9:0] v_exp;
        v_man = {1'b0, frac} + {23'd0, inc};
        v_exp = v_man[23] ? e_in + 10'sd1 : e_in;
        if (v_exp <= 10'sd0)
            f_pack = {sign, 31'd0};
        else if (v_exp >= 10'sd255)
            f_pack = {sign, 8'hFF, 23'd0};
        else
            f_pack = {sign, v_exp[7:0], v_man[22:0]};
    endfunction

    function automatic logic [4:0] f_lzc(input logic [26:0] v);
        f_lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) f_lzc = 5'(26 - i);
        end
    endfunction

    // Products: 0 = re*C, 1 = img*S, 2 = img*C, 3 = re*S
    logic [31:0] w_op  [4];
    logic [31:0] w_k   [4];
    logic [31:0] w_p2  [4];
    logic [31:0] w_out [2];

    assign w_op[0] = a_re;   assign w_k[0] = c_cos;
    assign w_op[1] = a_img;  assign w_k[1] = c_sin;
    assign w_op[2] = a_img;  assign w_k[2] = c_cos;
    assign w_op[3] = a_re;   assign w_k[3] = c_sin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mul
            logic              r1_sign;
            logic              r1_zero;
            logic signed [9:0] r1_exp;
            logic [47:0]       r1_man;
            logic [31:0]       r2_p;
            logic [46:0]       w_sh;
            logic              w_g;
            logic              w_r;
            logic              w_s;
            logic              w_inc;
            logic [31:0]       w_p;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r1_sign <= 1'b0;
                    r1_zero <= 1'b1;
                    r1_exp  <= 10'sd0;
                    r1_man  <= 48'd0;
                    r2_p    <= 32'd0;
                end else begin
                    r1_sign <= w_op[gi][31] ^ w_k[gi][31];
                    r1_zero <= (w_op[gi][30:23] == 8'd0);
                    r1_exp  <= $signed({2'b00, w_op[gi][30:23]})
                             + $signed({2'b00, w_k[gi][30:23]}) - 10'sd127;
                    r1_man  <= {24'd0, 1'b1, w_op[gi][22:0]} * {24'd0, 1'b1, w_k[gi][22:0]};
                    r2_p    <= w_p;
                end
            end

            // Product lies in [1,4): at most one right shift re-normalises it.
            assign w_sh = r1_man[47] ? r1_man[46:0] : {r1_man[45:0], 1'b0};
            assign w_g  = w_sh[23];
            assign w_r  = w_sh[22];
            assign w_s  = |w_sh[21:0];
`ifdef K11_ROUND_EN
            assign w_inc = w_g & (w_r | w_s | w_sh[24]);
`else
            logic w_unused_grs;
            assign w_unused_grs = w_g | w_r | w_s;
            assign w_inc = 1'b0;
`endif
            assign w_p = r1_zero ? {r1_sign, 31'd0}
                       : f_pack(r1_sign, r1_exp + (r1_man[47] ? 10'sd1 : 10'sd0),
                                w_sh[46:24], w_inc);
            assign w_p2[gi] = r2_p;
        end

        for (genvar li = 0; li < 2; li++) begin : g_add
            logic [31:0]       w_x;
            logic [31:0]       w_y;
            logic              w_swap;
            logic [31:0]       w_big;
            logic [31:0]       w_sml;
            logic [7:0]        w_d;
            logic [4:0]        w_dc;
            logic [57:0]       w_shf;
            logic [26:0]       w_bm;
            logic [26:0]       w_sm;
            logic [27:0]       w_sum;
            logic              r3_sign;
            logic [7:0]        r3_exp;
            logic [27:0]       r3_sum;
            logic [4:0]        w_lz;
            logic [26:0]       w_n;
            logic [22:0]       w_frac;
            logic              w_g4;
            logic              w_r4;
            logic              w_s4;
            logic              w_inc4;
            logic signed [9:0] w_e4;

            // The imaginary lane subtracts, so flip the sign of its second term.
            assign w_x    = w_p2[2*li];
            assign w_y    = w_p2[2*li+1] ^ ((li == 0) ? 32'h0000_0000 : 32'h8000_0000);
            assign w_swap = w_y[30:0] > w_x[30:0];
            assign w_big  = w_swap ? w_y : w_x;
            assign w_sml  = w_swap ? w_x : w_y;
            assign w_d    = w_big[30:23] - w_sml[30:23];
            assign w_dc   = (w_d > 8'd31) ? 5'd31 : w_d[4:0];
            assign w_shf  = {(w_sml[30:23] != 8'd0), w_sml[22:0], 34'd0} >> w_dc;
            assign w_bm   = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
            assign w_sm   = {w_shf[57:32], |w_shf[31:0]};
            assign w_sum  = (w_big[31] == w_sml[31]) ? {1'b0, w_bm} + {1'b0, w_sm}
                                                     : {1'b0, w_bm} - {1'b0, w_sm};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r3_sign <= 1'b0;
                    r3_exp  <= 8'd0;
                    r3_sum  <= 28'd0;
                end else begin
                    r3_sign <= w_big[31];
                    r3_exp  <= w_big[30:23];
                    r3_sum  <= w_sum;
                end
            end

            assign w_lz = f_lzc(r3_sum[26:0]);
            assign w_n  = r3_sum[26:0] << w_lz;

            always_comb begin
                if (r3_sum[27]) begin
                    w_frac = r3_sum[26:4];
                    w_g4   = r3_sum[3];
                    w_r4   = r3_sum[2];
                    w_s4   = |r3_sum[1:0];
                    w_e4   = $signed({2'b00, r3_exp}) + 10'sd1;
                end else begin
                    w_frac = w_n[25:3];
                    w_g4   = w_n[2];
                    w_r4   = w_n[1];
                    w_s4   = w_n[0];
                    w_e4   = $signed({2'b00, r3_exp}) - $signed({5'd0, w_lz});
                end
            end
`ifdef K11_ROUND_EN
            assign w_inc4 = w_g4 & (w_r4 | w_s4 | w_frac[0]);
`else
            logic w_unused_grs4;
            assign w_unused_grs4 = w_g4 | w_r4 | w_s4;
            assign w_inc4 = 1'b0;
`endif
            // A zero sum (including exact cancellation) is always +0.
            assign w_out[li] = (!r3_sum[27] && !w_n[26]) ? 32'd0
                             : f_pack(r3_sign, w_e4, w_frac, w_inc4);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_re  <= 32'd0;
            a1_img <= 32'd0;
        end else begin
            a1_re  <= w_out[0];
            a1_img <= w_out[1];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_k11.sv
`default_nettype none
// ============================================================================
// Module  : tb_k11
// Brief   : Self-checking bench for k11 against a double-precision model.
// Revision: 1.0
// ============================================================================
module tb_k11;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_re;
    logic [31:0] a_img;
    logic [31:0] a1_re;
    logic [31:0] a1_img;
    int          errors = 0;
    int          checks = 0;
    int          n_ids  = 0;

    localparam logic [31:0] CB = 32'h3E9E377A;
    localparam logic [31:0] SB = 32'h3F737871;
`ifdef K11_ROUND_EN
    localparam real TOLK = 2.5;
`else
    localparam real TOLK = 4.5;
`endif

    typedef struct {
        bit          ex_re;
        bit          ex_im;
        logic [31:0] er;
        logic [31:0] ei;
        logic [31:0] xr;
        logic [31:0] xi;
        int          id;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    k11 dut (
        .clk    (clk),
        .rst    (rst),
        .a_re   (a_re),
        .a_img  (a_img),
        .a1_re  (a1_re),
        .a1_img (a1_img)
    );

    function automatic real f2r(input logic [31:0] b);
        real m;
        if (b[30:23] == 8'd0) return 0.0;
        if (b[30:23] == 8'hFF) m = 1.0e39;
        else m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(b[30:23]) - 127.0));
        return b[31] ? -m : m;
    endfunction

    function automatic real ulp(input real m);
        real p;
        p = 1.0;
        if (m <= 0.0) return 0.0;
        for (int i = 0; i < 300 && p * 2.0 <= m; i++) p = p * 2.0;
        for (int i = 0; i < 300 && p > m; i++) p = p / 2.0;
        return p / 8388608.0;
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(110, 144));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    task automatic chk_bits(input string tag, input int id, input logic [31:0] got,
                            input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s#%0d got %h want %h", tag, id, got, want);
        end
    endtask

    task automatic chk_near(input string tag, input int id, input logic [31:0] got,
                            input real t1, input real t2);
        real v, m, m2, tol, g;
        bit  ok;
        v   = t1 + t2;
        m   = (t1 < 0.0) ? -t1 : t1;
        m2  = (t2 < 0.0) ? -t2 : t2;
        if (m2 > m) m = m2;
        tol = TOLK * ulp(m);
        g   = f2r(got);
        ok  = ((g - v) <= tol) && ((v - g) <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s#%0d got %h (%g) want %g tol %g", tag, id, got, g, v, tol);
        end
    endtask

    task automatic check(input exp_t e);
        real c, s;
        c = f2r(CB);
        s = f2r(SB);
        if (e.ex_re) chk_bits("re", e.id, a1_re, e.er);
        else         chk_near("re", e.id, a1_re, f2r(e.xr) * c, f2r(e.xi) * s);
        if (e.ex_im) chk_bits("im", e.id, a1_img, e.ei);
        else         chk_near("im", e.id, a1_img, f2r(e.xi) * c, -(f2r(e.xr) * s));
    endtask

    task automatic step(input logic [31:0] xr, input logic [31:0] xi,
                        input bit ex_re, input logic [31:0] er,
                        input bit ex_im, input logic [31:0] ei);
        exp_t e;
        a_re  = xr;
        a_img = xi;
        e.ex_re = ex_re; e.er = er; e.ex_im = ex_im; e.ei = ei;
        e.xr = xr; e.xi = xi; e.id = n_ids++;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 4) check(q.pop_front());
    endtask

    task automatic step_model(input logic [31:0] xr, input logic [31:0] xi);
        step(xr, xi, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Pipeline contents right after reset release: three all-zero results.
    task automatic prefill();
        exp_t e;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            e.ex_re = 1'b1; e.ex_im = 1'b1; e.er = 32'd0; e.ei = 32'd0;
            e.xr = 32'd0; e.xi = 32'd0; e.id = n_ids++;
            q.push_back(e);
        end
    endtask

    initial begin
        rst   = 1'b1;
        a_re  = rnd_f();
        a_img = rnd_f();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_bits("rst_re", i, a1_re, 32'd0);
            chk_bits("rst_im", i, a1_img, 32'd0);
            a_re  = rnd_f();
            a_img = rnd_f();
        end
        rst = 1'b0;
        prefill();

        step(32'h3F800000, 32'h00000000, 1'b1, CB, 1'b1, 32'hBF737871);
        step(32'h00000000, 32'h3F800000, 1'b1, SB, 1'b1, CB);
        step_model(32'h3F491A30, 32'h4246570A);
        step_model(32'hC142A3D7, 32'h4213570A);
        step_model(32'hBF491A30, 32'hC1361234);
        step_model(32'hC23CC097, 32'h4246570A);
        step(32'h00000000, 32'h00000000, 1'b1, 32'd0, 1'b1, 32'd0);
        step(SB, {1'b1, CB[30:0]}, 1'b1, 32'd0, 1'b0, 32'd0);
        step(32'h7F000000, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 1'b0, 32'd0);
        step(32'h00800000, 32'h00000001, 1'b1, 32'd0, 1'b1, 32'd0);
        step(32'h80800000, 32'h00000000, 1'b1, 32'd0, 1'b1, 32'd0);
        for (int i = 0; i < 40; i++) step_model(rnd_f(), rnd_f());

        #3 rst = 1'b1;
        #1;
        chk_bits("arst_re", 0, a1_re, 32'd0);
        chk_bits("arst_im", 0, a1_img, 32'd0);
        for (int i = 0; i < 2; i++) begin
            a_re  = rnd_f();
            a_img = rnd_f();
            @(posedge clk);
            #1;
            chk_bits("arst_hold_re", i, a1_re, 32'd0);
            chk_bits("arst_hold_im", i, a1_img, 32'd0);
        end
        rst = 1'b0;
        prefill();
        for (int i = 0; i < 8; i++) step_model(rnd_f(), rnd_f());
        for (int i = 0; i < 3; i++) step(32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
